// File: rtl/lane_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// lane_fetch_sequencer
// Fetch/PC sequencer for the split/unified lane datapath. Keeps one PC per lane
// (split mode) or one PC spanning all lanes (unified mode), drives the
// instruction-memory ports, applies branch redirects and sequences the
// IDLE -> FETCH -> EXEC (-> FLUSH on mode change) cycle with stall support.
//
// Optional feature macro: LANE_HALT_EN
//   defined   : a taken branch with zero shifted offset halts that lane
//               (unified: all lanes); halted lanes stop fetching and their PC
//               freezes; with every lane halted the sequencer parks in FETCH.
//   undefined : halted is constantly 0; a self-loop simply refetches.
//
// Ports
//   clk           clock, all state on rising edge
//   rst_n         synchronous active-low reset
//   mode          1 = unified, 0 = split (latched when FETCH is entered)
//   stall         hold the current instruction in EXEC
//   br_valid      per-lane branch taken (unified uses bit 0)
//   br_imm        per-lane signed immediates (unified: one signed vector)
//   pc            current PC(s)
//   imem_addr     per-lane instruction-memory address
//   imem_en       per-lane instruction-memory read enable
//   instr_valid   memory data valid for execute this cycle
//   reg_we_phase  register-file write permitted (EXEC cycle that completes)
//   fsm_state     debug state: IDLE=0, FETCH=1, EXEC=2, FLUSH=3
//   halted        per-lane halt flags
// -----------------------------------------------------------------------------
module lane_fetch_sequencer #(
   parameter int unsigned LANES       = 2,
   parameter int unsigned LANE_W      = 32,
   parameter int unsigned BR_SHIFT    = 2,
   parameter int unsigned LANE_STRIDE = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic                    stall,
   input  logic [LANES-1:0]        br_valid,
   input  logic [LANES*LANE_W-1:0] br_imm,
   output logic [LANES*LANE_W-1:0] pc,
   output logic [LANES*LANE_W-1:0] imem_addr,
   output logic [LANES-1:0]        imem_en,
   output logic [LANES-1:0]        instr_valid,
   output logic                    reg_we_phase,
   output logic [2:0]              fsm_state,
   output logic [LANES-1:0]        halted
);

   localparam int unsigned PC_W = LANES * LANE_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      FLUSH = 3'd3
   } state_t;

   state_t                  state_q, state_nxt;
   logic [PC_W-1:0]         pc_q, pc_nxt, pc_adv;
   logic                    mode_q, mode_nxt;
   logic [LANES-1:0]        halted_q, halted_nxt, halt_set;
   logic [LANES-1:0]        active_nxt, en_nxt, valid_nxt;
   logic [LANES-1:0]        en_q, valid_q;
   logic [PC_W-1:0]         addr_nxt, addr_q;
   logic signed [PC_W-1:0]  uni_off;
   logic signed [LANE_W-1:0] lane_off [LANES];

   // Branch offsets: arithmetic shift keeps negative redirects legal
   always_comb begin : branch_offsets
      uni_off = $signed(br_imm) >>> BR_SHIFT;
      for (int k = 0; k < LANES; k++) begin
         lane_off[k] = $signed(br_imm[k*LANE_W +: LANE_W]) >>> BR_SHIFT;
      end
   end

   // Candidate next PC; unified carries across lanes, split lanes wrap alone
   always_comb begin : pc_advance
      logic [LANE_W-1:0] lane_pc;
      pc_adv  = pc_q;
      lane_pc = '0;
      if (mode_q) begin
         if (!halted_q[0]) begin
            pc_adv = br_valid[0] ? pc_q + $unsigned(uni_off) : pc_q + PC_W'(1);
         end
      end else begin
         for (int k = 0; k < LANES; k++) begin
            lane_pc = pc_q[k*LANE_W +: LANE_W];
            if (!halted_q[k]) begin
               pc_adv[k*LANE_W +: LANE_W] = br_valid[k] ? lane_pc + $unsigned(lane_off[k])
                                                        : lane_pc + LANE_W'(1);
            end
         end
      end
   end

`ifdef LANE_HALT_EN
   // Self-loop detection: taken branch whose shifted offset is zero
   always_comb begin : halt_detect
      halt_set = '0;
      if (mode_q) begin
         halt_set = {LANES{br_valid[0] && (uni_off == '0)}};
      end else begin
         for (int k = 0; k < LANES; k++) begin
            halt_set[k] = br_valid[k] && (lane_off[k] == '0);
         end
      end
   end
`else
   assign halt_set = '0;
`endif

   // Next-state, next-PC and next registered-output values
   always_comb begin : next_state
      state_nxt  = state_q;
      pc_nxt     = pc_q;
      halted_nxt = halted_q;
      mode_nxt   = mode_q;
      active_nxt = '0;
      en_nxt     = '0;
      valid_nxt  = '0;
      addr_nxt   = '0;

      case (state_q)
         IDLE:  state_nxt = FETCH;
         // Parks here once every lane has halted
         FETCH: state_nxt = (&halted_q) ? FETCH : EXEC;
         EXEC: begin
            if (!stall) begin
               pc_nxt     = pc_adv;
               halted_nxt = halted_q | halt_set;
               state_nxt  = (mode != mode_q) ? FLUSH : FETCH;
            end
         end
         FLUSH: begin
            pc_nxt     = '0;
            halted_nxt = '0;
            state_nxt  = FETCH;
         end
         default: state_nxt = IDLE;
      endcase

      // Mode is captured on entry to FETCH and held for that fetch/execute pair
      if ((state_nxt == FETCH) && (state_q != FETCH)) begin
         mode_nxt = mode;
      end

      active_nxt = mode_nxt ? {{(LANES-1){1'b0}}, 1'b1} : {LANES{1'b1}};
      en_nxt     = (state_nxt == FETCH) ? (active_nxt & ~halted_nxt) : '0;
      valid_nxt  = (state_nxt == EXEC)  ? (active_nxt & ~halted_nxt) : '0;

      if (mode_nxt) begin
         addr_nxt[LANE_W-1:0] = pc_nxt[LANE_W-1:0];
      end else begin
         for (int k = 0; k < LANES; k++) begin
            addr_nxt[k*LANE_W +: LANE_W] = pc_nxt[k*LANE_W +: LANE_W]
                                         + LANE_W'(k * LANE_STRIDE);
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin : seq
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         mode_q   <= 1'b0;
         halted_q <= '0;
         en_q     <= '0;
         valid_q  <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_nxt;
         pc_q     <= pc_nxt;
         mode_q   <= mode_nxt;
         halted_q <= halted_nxt;
         en_q     <= en_nxt;
         valid_q  <= valid_nxt;
         addr_q   <= addr_nxt;
      end
   end

   // Write permission belongs to the EXEC cycle that actually retires
   assign reg_we_phase = (state_q == EXEC) && !stall;

   assign pc          = pc_q;
   assign imem_addr   = addr_q;
   assign imem_en     = en_q;
   assign instr_valid = valid_q;
   assign fsm_state   = state_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_lane_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lane_fetch_sequencer
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_lane_fetch_sequencer;

   localparam int unsigned LANES  = 2;
   localparam int unsigned LANE_W = 32;

   logic                    clk;
   logic                    rst_n;
   logic                    mode;
   logic                    stall;
   logic [LANES-1:0]        br_valid;
   logic [LANES*LANE_W-1:0] br_imm;
   logic [LANES*LANE_W-1:0] pc;
   logic [LANES*LANE_W-1:0] imem_addr;
   logic [LANES-1:0]        imem_en;
   logic [LANES-1:0]        instr_valid;
   logic                    reg_we_phase;
   logic [2:0]              fsm_state;
   logic [LANES-1:0]        halted;

   lane_fetch_sequencer #(
      .LANES(LANES), .LANE_W(LANE_W), .BR_SHIFT(2), .LANE_STRIDE(512)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .stall(stall),
      .br_valid(br_valid), .br_imm(br_imm), .pc(pc), .imem_addr(imem_addr),
      .imem_en(imem_en), .instr_valid(instr_valid), .reg_we_phase(reg_we_phase),
      .fsm_state(fsm_state), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state (debug encoding: 0 idle, 1 fetch, 2 exec, 3 flush)
   int          m_state;
   logic [63:0] m_pc;
   logic        m_mode;
   logic [1:0]  m_halt;
   bit          m_ok = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of the specified behaviour
   task automatic model_step(input logic r, input logic m, input logic s,
                             input logic [1:0] bv, input logic [63:0] imm);
      logic [63:0] uoff;
      logic [31:0] lp, lo;
      logic [1:0]  hs;
      hs = 2'b00;
      if (!r) begin
         m_state = 0; m_pc = 64'h0; m_mode = 1'b0; m_halt = 2'b00; m_ok = 1'b1;
      end else if (m_state == 0) begin
         m_state = 1; m_mode = m;
      end else if (m_state == 1) begin
         if (m_halt != 2'b11) m_state = 2;
      end else if (m_state == 2) begin
         if (!s) begin
            if (m_mode) begin
               uoff = $signed(imm) >>> 2;
               if (!m_halt[0]) m_pc = bv[0] ? m_pc + uoff : m_pc + 64'd1;
               if (bv[0] && uoff == 64'h0) hs = 2'b11;
            end else begin
               for (int k = 0; k < 2; k++) begin
                  lp = m_pc[32*k +: 32];
                  lo = $signed(imm[32*k +: 32]) >>> 2;
                  if (!m_halt[k]) lp = bv[k] ? lp + lo : lp + 32'd1;
                  m_pc[32*k +: 32] = lp;
                  if (bv[k] && lo == 32'h0) hs[k] = 1'b1;
               end
            end
`ifdef LANE_HALT_EN
            m_halt = m_halt | hs;
`endif
            if (m != m_mode) m_state = 3;
            else begin m_state = 1; m_mode = m; end
         end
      end else begin
         m_pc = 64'h0; m_halt = 2'b00; m_state = 1; m_mode = m;
      end
   endtask

   task automatic check_outs(input string tag);
      logic [1:0]  act;
      logic [63:0] e_addr;
      act    = m_mode ? 2'b01 : 2'b11;
      e_addr = m_mode ? {32'h0, m_pc[31:0]} : {m_pc[63:32] + 32'd512, m_pc[31:0]};
      chk({tag, ".state"}, 64'(fsm_state), 64'(m_state));
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".imem_en"}, 64'(imem_en), 64'((m_state == 1) ? (act & ~m_halt) : 2'b00));
      chk({tag, ".instr_valid"}, 64'(instr_valid), 64'((m_state == 2) ? (act & ~m_halt) : 2'b00));
      chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
      if (m_state != 0) chk({tag, ".imem_addr"}, imem_addr, e_addr);
   endtask

   // Drive one cycle of inputs, check the combinational write phase, clock, check
   task automatic run(input logic r, input logic m, input logic s,
                      input logic [1:0] bv, input logic [63:0] imm, input string tag);
      rst_n = r; mode = m; stall = s; br_valid = bv; br_imm = imm;
      #1;
      if (m_ok) chk({tag, ".reg_we"}, 64'(reg_we_phase), 64'((m_state == 2) && !s));
      @(posedge clk);
      model_step(r, m, s, bv, imm);
      #1;
      check_outs(tag);
   endtask

   typedef struct {
      logic        r;
      logic        m;
      logic        s;
      logic [1:0]  bv;
      logic [63:0] imm;
      int          e_state;
      logic [63:0] e_pc;
      logic [1:0]  e_en;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic m, input logic s, input logic [1:0] bv,
                      input logic [63:0] imm, input int st, input logic [63:0] p,
                      input logic [1:0] en);
      vec_t v;
      v.r = r; v.m = m; v.s = s; v.bv = bv; v.imm = imm;
      v.e_state = st; v.e_pc = p; v.e_en = en;
      tbl.push_back(v);
   endtask

   initial begin
      logic        rm;
      logic [31:0] li [2];
      logic [63:0] ri;

      rst_n = 1'b0; mode = 1'b0; stall = 1'b0; br_valid = '0; br_imm = '0;

      // Reset, split sequential, branches, ignored branch, stall, mode change
      for (int i = 0; i < 3; i++) add(0, 0, 0, 2'b00, 64'h0, 0, 64'h0, 2'b00);
      add(1, 0, 0, 2'b00, 64'h0, 1, 64'h0, 2'b11);
      add(1, 0, 0, 2'b00, 64'h0, 2, 64'h0, 2'b00);
      for (int i = 1; i <= 5; i++) begin
         add(1, 0, 0, 2'b00, 64'h0, 1, {32'(i), 32'(i)}, 2'b11);
         add(1, 0, 0, 2'b00, 64'h0, 2, {32'(i), 32'(i)}, 2'b00);
      end
      add(1, 0, 0, 2'b10, 64'h00000020_00000000, 1, 64'h0000000D_00000006, 2'b11);
      add(1, 0, 0, 2'b11, 64'h12345678_9ABCDEF0, 2, 64'h0000000D_00000006, 2'b00);
      add(1, 0, 0, 2'b01, 64'h00000000_FFFFFFF8, 1, 64'h0000000E_00000004, 2'b11);
      add(1, 0, 0, 2'b00, 64'h0, 2, 64'h0000000E_00000004, 2'b00);
      for (int i = 0; i < 4; i++) add(1, 0, 1, 2'b00, 64'h0, 2, 64'h0000000E_00000004, 2'b00);
      add(1, 0, 0, 2'b00, 64'h0, 1, 64'h0000000F_00000005, 2'b11);
      add(1, 1, 0, 2'b00, 64'h0, 2, 64'h0000000F_00000005, 2'b00);
      add(1, 1, 0, 2'b00, 64'h0, 3, 64'h00000010_00000006, 2'b00);
      add(1, 1, 0, 2'b00, 64'h0, 1, 64'h0, 2'b01);
      add(1, 1, 0, 2'b00, 64'h0, 2, 64'h0, 2'b00);
      add(1, 1, 0, 2'b00, 64'h0, 1, 64'h1, 2'b01);

      for (int i = 0; i < tbl.size(); i++) begin
         run(tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].bv, tbl[i].imm, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.tbl_state", i), 64'(fsm_state), 64'(tbl[i].e_state));
         chk($sformatf("vec%0d.tbl_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("vec%0d.tbl_en", i), 64'(imem_en), 64'(tbl[i].e_en));
      end

      // Unified carry across the lane boundary
      run(1, 1, 0, 2'b00, 64'h0, "ucarry0");
      run(1, 1, 0, 2'b01, 64'h00000003_FFFFFFF8, "ucarry1");
      chk("ucarry.pc_pre", pc, 64'h00000000_FFFFFFFF);
      run(1, 1, 0, 2'b00, 64'h0, "ucarry2");
      run(1, 1, 0, 2'b00, 64'h0, "ucarry3");
      chk("ucarry.pc_post", pc, 64'h00000001_00000000);
      chk("ucarry.addr", imem_addr, 64'h0);

      // Split lanes wrap independently
      run(0, 0, 0, 2'b00, 64'h0, "scarry0");
      run(1, 0, 0, 2'b00, 64'h0, "scarry1");
      run(1, 0, 0, 2'b00, 64'h0, "scarry2");
      run(1, 0, 0, 2'b11, 64'hFFFFFFFC_FFFFFFF8, "scarry3");
      run(1, 0, 0, 2'b00, 64'h0, "scarry4");
      run(1, 0, 0, 2'b00, 64'h0, "scarry5");
      chk("scarry.pc_pre", pc, 64'h00000000_FFFFFFFF);
      chk("scarry.addr_pre", imem_addr, 64'h00000200_FFFFFFFF);
      run(1, 0, 0, 2'b00, 64'h0, "scarry6");
      run(1, 0, 0, 2'b00, 64'h0, "scarry7");
      chk("scarry.pc_post", pc, 64'h00000001_00000000);
      chk("scarry.addr_post", imem_addr, 64'h00000201_00000000);

      // Reset asserted in the middle of a stall
      run(1, 0, 0, 2'b00, 64'h0, "rststall0");
      run(1, 0, 1, 2'b00, 64'h0, "rststall1");
      run(1, 0, 1, 2'b00, 64'h0, "rststall2");
      run(0, 0, 1, 2'b00, 64'h0, "rststall3");
      chk("rststall.state", 64'(fsm_state), 64'd0);
      chk("rststall.pc", pc, 64'h0);
      run(1, 0, 0, 2'b00, 64'h0, "rststall4");
      chk("rststall.fetch", 64'(fsm_state), 64'd1);

      // Self-loop on lane 0
      run(1, 0, 0, 2'b00, 64'h0, "loop0");
      run(1, 0, 0, 2'b01, 64'h0, "loop1");
`ifdef LANE_HALT_EN
      chk("halt.flags", 64'(halted), 64'h1);
      chk("halt.pc", pc, 64'h00000001_00000000);
      chk("halt.en", 64'(imem_en), 64'h2);
      run(1, 0, 0, 2'b00, 64'h0, "loop2");
      chk("halt.valid", 64'(instr_valid), 64'h2);
      run(1, 0, 0, 2'b00, 64'h0, "loop3");
      chk("halt.pc2", pc, 64'h00000002_00000000);
      run(1, 0, 0, 2'b00, 64'h0, "loop4");
      run(1, 0, 0, 2'b10, 64'h0, "loop5");
      chk("halt.all", 64'(halted), 64'h3);
      run(1, 0, 0, 2'b00, 64'h0, "loop6");
      chk("halt.park", 64'(fsm_state), 64'd1);
      chk("halt.park_en", 64'(imem_en), 64'h0);
`else
      chk("loop.flags", 64'(halted), 64'h0);
      chk("loop.pc", pc, 64'h00000001_00000000);
      chk("loop.en", 64'(imem_en), 64'h3);
`endif

      // Randomized traffic against the model
      run(0, 0, 0, 2'b00, 64'h0, "rnd_rst");
      rm = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) rm = ~rm;
         for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 3))
               0: li[k] = 32'h0;
               1: li[k] = 32'($urandom_range(0, 64));
               2: li[k] = 32'h0 - 32'($urandom_range(0, 64));
               default: li[k] = $urandom;
            endcase
         end
         ri = {li[1], li[0]};
         if ($urandom_range(0, 7) == 0) ri = {$urandom, $urandom};
         run(($urandom_range(0, 63) != 0), rm, ($urandom_range(0, 3) == 0),
             2'($urandom), ri, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
